// File: rtl/sim_watchdog_if.sv
`default_nettype none
// ============================================================================
// Module   : sim_watchdog_if
// Brief    : Harness-side signal bundle between the DUT and the sim watchdog.
// Revision : 1.0 - initial release
// ============================================================================
interface sim_watchdog_if #(
   parameter int CNT_W = 32
);
   logic             passed;
   logic             failed;
   logic             dut_reset;
   logic [CNT_W-1:0] cyc_cnt;
   logic             done;
   logic [1:0]       status;
   logic [CNT_W-1:0] end_cycle;

   modport master (
      output passed, failed,
      input  dut_reset, cyc_cnt, done, status, end_cycle
   );

   modport slave (
      input  passed, failed,
      output dut_reset, cyc_cnt, done, status, end_cycle
   );
endinterface
`default_nettype wire

// File: rtl/sim_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : sim_watchdog
// Brief    : DUT reset sequencing, cycle counter, pass/fail/timeout verdict.
// Revision : 1.0 - initial release
// ============================================================================
module sim_watchdog #(
   parameter int CNT_W        = 32,
   parameter int MAX_CYCLES   = 100000,
   parameter int RESET_CYCLES = 4,
   parameter int PASS_HOLD    = 1
) (
   input  logic          clk,
   input  logic          reset_async,
   sim_watchdog_if.slave bus
);

   localparam int c_HW = $clog2(RESET_CYCLES + 1);
   localparam int c_PW = $clog2(PASS_HOLD + 1);
   localparam logic [c_HW-1:0]  c_HOLD_LAST = c_HW'(RESET_CYCLES - 1);
   localparam logic [c_PW-1:0]  c_PASS_LAST = c_PW'(PASS_HOLD - 1);
   localparam logic [CNT_W-1:0] c_MAX       = CNT_W'(MAX_CYCLES);

   if (MAX_CYCLES < 1 || longint'(MAX_CYCLES) >= (longint'(1) << CNT_W)) begin : g_bad_max
      $error("sim_watchdog: MAX_CYCLES out of range for CNT_W");
   end
   if (RESET_CYCLES < 1) begin : g_bad_reset
      $error("sim_watchdog: RESET_CYCLES must be >= 1");
   end
   if (PASS_HOLD < 1) begin : g_bad_pass
      $error("sim_watchdog: PASS_HOLD must be >= 1");
   end

   typedef enum logic [2:0] {
      ST_HOLD = 3'd0,
      ST_RUN  = 3'd1,
      ST_PASS = 3'd2,
      ST_FAIL = 3'd3,
      ST_TMO  = 3'd4
   } state_t;

   logic [1:0]       r_sync;
   logic             w_rst_sync;
   state_t           r_state,      w_state_nxt;
   logic [c_HW-1:0]  r_hold_cnt,   w_hold_nxt;
   logic [c_PW-1:0]  r_pass_cnt,   w_pass_nxt;
   logic [CNT_W-1:0] r_cyc_cnt,    w_cyc_nxt;
   logic             r_done,       w_done_nxt;
   logic [1:0]       r_status,     w_status_nxt;
   logic [CNT_W-1:0] r_end_cycle,  w_end_nxt;

   // Assertion is immediate; release reaches the FSM two edges later.
   always_ff @(posedge clk or posedge reset_async) begin
      if (reset_async) r_sync <= 2'b11;
      else             r_sync <= {r_sync[0], 1'b0};
   end
   assign w_rst_sync = r_sync[1];

   always_ff @(posedge clk or posedge reset_async) begin
      if (reset_async) begin
         r_state     <= ST_HOLD;
         r_hold_cnt  <= '0;
         r_pass_cnt  <= '0;
         r_cyc_cnt   <= '0;
         r_done      <= 1'b0;
         r_status    <= 2'b00;
         r_end_cycle <= '0;
      end else if (!w_rst_sync) begin
         r_state     <= w_state_nxt;
         r_hold_cnt  <= w_hold_nxt;
         r_pass_cnt  <= w_pass_nxt;
         r_cyc_cnt   <= w_cyc_nxt;
         r_done      <= w_done_nxt;
         r_status    <= w_status_nxt;
         r_end_cycle <= w_end_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_hold_nxt   = r_hold_cnt;
      w_pass_nxt   = r_pass_cnt;
      w_cyc_nxt    = r_cyc_cnt;
      w_done_nxt   = r_done;
      w_status_nxt = r_status;
      w_end_nxt    = r_end_cycle;
      case (r_state)
         ST_HOLD: begin
            if (r_hold_cnt == c_HOLD_LAST) begin
               w_state_nxt = ST_RUN;
               w_cyc_nxt   = CNT_W'(1);
            end else begin
               w_hold_nxt  = r_hold_cnt + c_PW'(0) + c_HW'(1);
            end
         end
         ST_RUN: begin
            w_pass_nxt = bus.passed ? r_pass_cnt + c_PW'(1) : '0;
            // Priority: fail, then pass, then timeout; cyc_cnt freezes on the decision.
            if (bus.failed) begin
               w_state_nxt  = ST_FAIL;
               w_status_nxt = 2'b10;
               w_done_nxt   = 1'b1;
               w_end_nxt    = r_cyc_cnt;
            end else if (bus.passed && r_pass_cnt == c_PASS_LAST) begin
               w_state_nxt  = ST_PASS;
               w_status_nxt = 2'b01;
               w_done_nxt   = 1'b1;
               w_end_nxt    = r_cyc_cnt;
            end else if (r_cyc_cnt == c_MAX) begin
               w_state_nxt  = ST_TMO;
               w_status_nxt = 2'b11;
               w_done_nxt   = 1'b1;
               w_end_nxt    = r_cyc_cnt;
            end else begin
               w_cyc_nxt    = r_cyc_cnt + CNT_W'(1);
            end
         end
         default: ;
      endcase
   end

   assign bus.dut_reset = (r_state == ST_HOLD);
   assign bus.cyc_cnt   = r_cyc_cnt;
   assign bus.done      = r_done;
   assign bus.status    = r_status;
   assign bus.end_cycle = r_end_cycle;

endmodule
`default_nettype wire

// File: tb/tb_sim_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : tb_sim_watchdog
// Brief    : Self-checking bench for sim_watchdog (three parameterisations).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sim_watchdog;

   logic       clk = 1'b0;
   logic       reset_async;
   logic [2:0] p_in;
   logic [2:0] f_in;
   int         sel;
   int         checks   = 0;
   int         failures = 0;
   bit         pv [0:255];
   bit         fv [0:255];
   int         d_r;
   logic [1:0] st_r;

   always #5 clk = ~clk;

   sim_watchdog_if #(.CNT_W(32)) ifa ();
   sim_watchdog_if #(.CNT_W(32)) ifb ();
   sim_watchdog_if #(.CNT_W(32)) ifc ();

   assign ifa.passed = p_in[0];
   assign ifa.failed = f_in[0];
   assign ifb.passed = p_in[1];
   assign ifb.failed = f_in[1];
   assign ifc.passed = p_in[2];
   assign ifc.failed = f_in[2];

   sim_watchdog #(.CNT_W(32)) u_a (
      .clk(clk), .reset_async(reset_async), .bus(ifa)
   );
   sim_watchdog #(.CNT_W(32), .MAX_CYCLES(60), .PASS_HOLD(3)) u_b (
      .clk(clk), .reset_async(reset_async), .bus(ifb)
   );
   sim_watchdog #(.CNT_W(32), .MAX_CYCLES(25)) u_c (
      .clk(clk), .reset_async(reset_async), .bus(ifc)
   );

   logic        m_dr, m_done;
   logic [1:0]  m_st;
   logic [31:0] m_cyc, m_end;

   always_comb begin
      m_dr = ifa.dut_reset; m_done = ifa.done; m_st = ifa.status;
      m_cyc = ifa.cyc_cnt;  m_end = ifa.end_cycle;
      case (sel)
         1: begin
            m_dr = ifb.dut_reset; m_done = ifb.done; m_st = ifb.status;
            m_cyc = ifb.cyc_cnt;  m_end = ifb.end_cycle;
         end
         2: begin
            m_dr = ifc.dut_reset; m_done = ifc.done; m_st = ifc.status;
            m_cyc = ifc.cyc_cnt;  m_end = ifc.end_cycle;
         end
         default: ;
      endcase
   end

   function automatic int max_of(input int s);
      return (s == 1) ? 60 : (s == 2) ? 25 : 100000;
   endfunction

   function automatic int ph_of(input int s);
      return (s == 1) ? 3 : 1;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic clear_stim();
      for (int k = 0; k < 256; k++) begin
         pv[k] = 1'b0;
         fv[k] = 1'b0;
      end
   endtask

   // Verdict from the rules: first failing RUN cycle, first cycle closing a
   // run of PASS_HOLD consecutive passes, or the MAX_CYCLES-th cycle.
   task automatic model(input int s, output int d, output logic [1:0] st);
      int streak;
      int lim;
      streak = 0;
      d      = 0;
      st     = 2'b00;
      lim    = (max_of(s) < 255) ? max_of(s) : 255;
      for (int k = 1; k <= lim; k++) begin
         if (fv[k]) begin d = k; st = 2'b10; return; end
         streak = pv[k] ? streak + 1 : 0;
         if (streak >= ph_of(s)) begin d = k; st = 2'b01; return; end
         if (k == max_of(s)) begin d = k; st = 2'b11; return; end
      end
   endtask

   // Leaves the bench at posedge+1 of the first RUN cycle.
   task automatic restart(input int s);
      sel = s;
      p_in = '0;
      f_in = '0;
      reset_async = 1'b1;
      @(posedge clk); #1;
      chk("rst_dut_reset", m_dr, 1);
      chk("rst_cyc_cnt", m_cyc, 0);
      chk("rst_done", m_done, 0);
      chk("rst_status", m_st, 0);
      chk("rst_end_cycle", m_end, 0);
      @(negedge clk);
      reset_async = 1'b0;
      for (int e = 0; e < 5; e++) begin
         @(posedge clk); #1;
         chk($sformatf("hold_dut_reset@%0d", e), m_dr, 1);
         chk($sformatf("hold_cyc_cnt@%0d", e), m_cyc, 0);
      end
      @(posedge clk); #1;
   endtask

   task automatic run_seq(input int s, input int n, output int d_o, output logic [1:0] st_o);
      int d;
      logic [1:0] st;
      model(s, d, st);
      for (int k = 1; k <= n; k++) begin
         chk($sformatf("dut_reset@%0d", k), m_dr, 0);
         if (d != 0 && k > d) begin
            chk($sformatf("done@%0d", k), m_done, 1);
            chk($sformatf("status@%0d", k), m_st, st);
            chk($sformatf("end_cycle@%0d", k), m_end, d);
            chk($sformatf("cyc_cnt_frozen@%0d", k), m_cyc, d);
         end else begin
            chk($sformatf("done@%0d", k), m_done, 0);
            chk($sformatf("status@%0d", k), m_st, 0);
            chk($sformatf("end_cycle@%0d", k), m_end, 0);
            chk($sformatf("cyc_cnt@%0d", k), m_cyc, k);
         end
         p_in[s] = pv[k];
         f_in[s] = fv[k];
         @(posedge clk); #1;
      end
      p_in = '0;
      f_in = '0;
      d_o  = d;
      st_o = st;
   endtask

   typedef struct {
      int         sel;
      int         p_lo;
      int         p_hi;
      int         f_at;
      bit         tog;
      int         n;
      logic [1:0] st;
      int         endc;
   } vec_t;

   vec_t tbl [9];

   initial begin
      reset_async = 1'b1;
      p_in = '0;
      f_in = '0;
      sel  = 0;

      tbl[0] = '{0, 50, 50,  0, 1'b0, 155, 2'b01, 50};
      tbl[1] = '{0,  7,  7,  7, 1'b1,  30, 2'b10,  7};
      tbl[2] = '{2,  0,  0,  0, 1'b0,  40, 2'b11, 25};
      tbl[3] = '{2, 25, 25,  0, 1'b0,  40, 2'b01, 25};
      tbl[4] = '{1, 30, 32,  0, 1'b0,  50, 2'b01, 32};
      tbl[5] = '{1, 10, 11, 40, 1'b0,  60, 2'b10, 40};
      tbl[6] = '{2,  0,  0, 25, 1'b0,  35, 2'b10, 25};
      tbl[7] = '{2, 24, 25,  0, 1'b0,  35, 2'b01, 24};
      tbl[8] = '{1,  5,  7,  0, 1'b0,  20, 2'b01,  7};

      for (int i = 0; i < 9; i++) begin
         clear_stim();
         if (tbl[i].p_lo > 0)
            for (int k = tbl[i].p_lo; k <= tbl[i].p_hi; k++) pv[k] = 1'b1;
         if (tbl[i].f_at > 0) fv[tbl[i].f_at] = 1'b1;
         if (tbl[i].tog)
            for (int k = tbl[i].f_at + 1; k <= tbl[i].n; k++) fv[k] = k[0];
         restart(tbl[i].sel);
         run_seq(tbl[i].sel, tbl[i].n, d_r, st_r);
         chk($sformatf("tbl%0d_done", i), m_done, 1);
         chk($sformatf("tbl%0d_status", i), m_st, tbl[i].st);
         chk($sformatf("tbl%0d_end_cycle", i), m_end, tbl[i].endc);
      end

      // PASS_HOLD=3: a two-cycle pass burst must not be accepted.
      clear_stim();
      pv[20] = 1'b1; pv[21] = 1'b1;
      pv[30] = 1'b1; pv[31] = 1'b1; pv[32] = 1'b1;
      restart(1);
      run_seq(1, 45, d_r, st_r);
      chk("hold3_status", m_st, 2'b01);
      chk("hold3_end_cycle", m_end, 32);

      // Mid-run asynchronous reset, with the MAX_CYCLES=25 instance already timed out.
      clear_stim();
      restart(0);
      run_seq(0, 40, d_r, st_r);
      chk("c_timeout_done", ifc.done, 1);
      chk("c_timeout_status", ifc.status, 2'b11);
      chk("a_cyc_before_rst", ifa.cyc_cnt, 41);
      #3;
      reset_async = 1'b1;
      #1;
      chk("async_a_cyc_cnt", ifa.cyc_cnt, 0);
      chk("async_a_dut_reset", ifa.dut_reset, 1);
      chk("async_a_done", ifa.done, 0);
      chk("async_c_done", ifc.done, 0);
      chk("async_c_status", ifc.status, 0);
      chk("async_c_end_cycle", ifc.end_cycle, 0);
      restart(0);
      run_seq(0, 10, d_r, st_r);

      for (int it = 0; it < 40; it++) begin
         int s;
         s = 1 + int'($urandom_range(0, 1));
         clear_stim();
         for (int k = 1; k <= 80; k++) begin
            pv[k] = ($urandom_range(0, 2) == 0);
            fv[k] = ($urandom_range(0, 39) == 0);
         end
         restart(s);
         run_seq(s, 70, d_r, st_r);
         chk($sformatf("rnd%0d_done", it), m_done, (d_r != 0) ? 1 : 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
